// File: rtl/combine_n.sv
// N-channel AXI-Stream beat aligner: per-lane FIFOs absorb skew and
// one output beat is formed when every enabled lane has a sample.
module combine_n #(
  parameter int NCH   = 4,
  parameter int DW    = 24,
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_enable,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  input  logic [NCH-1:0]    s_axis_tvalid,
  output logic [NCH-1:0]    s_axis_tready,
  output logic [NCH*DW-1:0] m_axis_tdata,
  output logic [NCH-1:0]    m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CW-1:0]     beat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0]     r_mem [NCH][DEPTH];
  logic [AW-1:0]     r_wp  [NCH];
  logic [AW-1:0]     r_rp  [NCH];
  logic [AW:0]       r_cnt [NCH];
  logic [NCH*DW-1:0] r_data;
  logic [NCH-1:0]    r_user;
  logic              r_vld;
  logic [CW-1:0]     r_bc;

  logic [NCH-1:0]    w_nempty;
  logic [NCH-1:0]    w_rdy;
  logic [NCH-1:0]    w_push;
  logic [NCH*DW-1:0] w_head;
  logic              w_have;
  logic              w_load;

  // Disabled lanes always accept and drop, so producers never stall on them.
  always_comb begin
    w_nempty = '0;
    w_rdy    = '0;
    w_push   = '0;
    w_head   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_nempty[i] = (r_cnt[i] != '0);
      w_rdy[i]    = !ch_enable[i] || (r_cnt[i] != L_FULL);
      w_push[i]   = ch_enable[i] && s_axis_tvalid[i] && w_rdy[i];
      w_head[i*DW +: DW] = ch_enable[i] ? r_mem[i][r_rp[i]] : '0;
    end
  end

  assign w_have = (&(w_nempty | ~ch_enable)) && (|ch_enable);
  assign w_load = w_have && (!r_vld || m_axis_tready);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wp[i]] <= s_axis_tdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_enable[i]) begin
          r_wp[i]  <= '0;
          r_rp[i]  <= '0;
          r_cnt[i] <= '0;
        end else begin
          if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
          if (w_load)    r_rp[i] <= r_rp[i] + 1'b1;
          case ({w_push[i], w_load})
            2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
            2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
            default: r_cnt[i] <= r_cnt[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_user <= '0;
    end else if (w_load) begin
      r_vld  <= 1'b1;
      r_data <= w_head;
      r_user <= ch_enable;
    end else if (r_vld && m_axis_tready) begin
      r_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bc <= '0;
    end else if (r_vld && m_axis_tready) begin
      r_bc <= r_bc + 1'b1;
    end
  end

  assign s_axis_tready = w_rdy;
  assign m_axis_tdata  = r_data;
  assign m_axis_tuser  = r_user;
  assign m_axis_tvalid = r_vld;
  assign beat_count    = r_bc;

endmodule
